load_store_unit: RTL and testbench
==================================

# load_store_unit

Sequencer between the execute stage and the word-wide `DataMemory`; it turns byte, halfword and word load/store requests into word accesses. Sub-word stores use a read-modify-write sequence. Loads are sign- or zero-extended. Misaligned or illegal requests fault without touching memory. It owns the memory-side enable and address lines, so memory is accessed only through this block.

## Interface
- `ADDR_W`, 32: request byte-address width.
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; high only in IDLE.
- `req_write`  in  1  1 = store, 0 = load.
- `req_funct3`  in  3  RV32I width code: 000 B, 001 H, 010 W, 100 BU, 101 HU. BU and HU are legal for loads only.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data; low bits are used for B and H.
- `resp_valid`  out  1  one-cycle pulse; the response fields below are valid.
- `resp_rdata`  out  32  extended load data; 0 for stores and faults.
- `resp_fault`  out  1  misaligned address or illegal funct3.
- `mem_access_addr`  out  32  word index = `req_addr >> 2` (latched).
- `mem_in`  out  32  write word.
- `mem_write_en`  out  1  write strobe.
- `mem_read_en`  out  1  read enable.
- `mem_out`  in  32  combinational read data from memory.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. On `req_valid` the unit latches addr, funct3, write and wdata.
  - Fault (H/HU with addr[0]≠0, W with addr[1:0]≠0, illegal funct3, or BU/HU on store) → RESP with fault=1.
  - Load or sub-word store → READ.
  - SW → WRITE.
- READ: `mem_read_en`=1 and `mem_out` is captured into a word register.
  - Load → RESP, with extracted data registered into `resp_rdata`.
  - Store → WRITE.
- WRITE: `mem_write_en`=1 (gated by ~`rst`).
  - SW: `mem_in` = wdata.
  - SB/SH: `mem_in` = captured word with the lane selected by addr[1:0] replaced by wdata[7:0] or wdata[15:0]. Other lanes are unchanged.
  - → RESP.
- RESP: `resp_valid`=1 for one cycle → IDLE. `resp_rdata` and `resp_fault` hold until the next RESP.
- Lane extraction: LB/LBU use byte addr[1:0]; LH/LHU use halfword addr[1]. Little-endian. LB/LH sign-extend from bit 7/15; BU/HU zero-extend.
- `mem_access_addr` is driven from the latched address in all states. Memory enables are 0 outside READ/WRITE.

## Timing
- Reset (`rst` high at a rising edge) puts the unit in IDLE and clears all registers.
  - After reset: `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `mem_*_en`=0, `mem_access_addr`=0, `mem_in`=0, `req_ready`=1.
- Accept edge = T. `resp_valid` is high in the cycle after edge:
  - fault: T+1
  - load: T+2
  - SW: T+2
  - SB/SH: T+3
- Memory write commits at the edge that ends the WRITE cycle. A load immediately following sees the new value.
- Reset mid-operation aborts the operation with no response.
  - A write in progress is suppressed only if `rst` is high during the WRITE cycle.
- `req_valid` outside IDLE is ignored (not latched). The requester must hold the request until `req_ready`.
- Back-to-back requests: next accept is at the edge after RESP, so there is at most one outstanding request.
- Word index wraps per memory depth; the unit does not range-check.

## Structure
- `lsu_pkg`: funct3 constants (F3_B/H/W/BU/HU), state enum encoding, `WORD_W`=32.
- Sub-module `lsu_align`, purely combinational:
  - inputs: addr[1:0], funct3, word, wdata
  - outputs: extended load data, merged store word, misaligned/illegal flag
- The FSM and registers stay in `load_store_unit`.

## Test plan
- Memory word 3 = 0x80FF_1234. LB at addr 0x0F → resp_rdata 0xFFFF_FF80 at T+2. LBU at the same address → 0x0000_0080.
- Word 3 = 0xAABB_CCDD. SB addr 0x0D, wdata 0x0000_0011 → word 3 = 0xAABB_11DD. Response at T+3 with fault=0.
- SH addr 0x0E, wdata 0x5566 → word 3 upper half = 0x5566. LH at the same address → 0x0000_5566. LHU of 0x8001 → 0x0000_8001.
- LW addr 0x06 → fault=1 at T+1, rdata=0, and `mem_read_en`/`mem_write_en` never asserted. Same for funct3=011 and for BU on store.
- SW addr 0x10, wdata 0xDEAD_BEEF, then LW addr 0x10 back-to-back → rdata 0xDEAD_BEEF. `req_ready` is low during busy states.
- SB accepted, then `rst` asserted during the WRITE cycle → memory unchanged, no `resp_valid`, and all outputs at reset values after the edge.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared constants for the load/store unit: RV32I width codes, FSM state
// encodings and the memory word width.
package lsu_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: load extraction/extension, sub-word store merge
// and the misaligned/illegal request check.
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]        i_addr,
    input  logic [2:0]        i_funct3,
    input  logic              i_write,
    input  logic [WORD_W-1:0] i_word,
    input  logic [WORD_W-1:0] i_wdata,
    output logic [WORD_W-1:0] o_load_data,
    output logic [WORD_W-1:0] o_store_word,
    output logic              o_fault
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_word[{i_addr, 3'b000} +: 8];
        w_half = i_addr[1] ? i_word[31:16] : i_word[15:0];
    end

    always_comb begin
        o_fault = 1'b0;
        case (i_funct3)
            F3_B:    o_fault = 1'b0;
            F3_H:    o_fault = i_addr[0];
            F3_W:    o_fault = |i_addr;
            F3_BU:   o_fault = i_write;
            F3_HU:   o_fault = i_write | i_addr[0];
            default: o_fault = 1'b1;
        endcase
    end

    always_comb begin
        o_load_data = '0;
        case (i_funct3)
            F3_B:    o_load_data = {{24{w_byte[7]}}, w_byte};
            F3_H:    o_load_data = {{16{w_half[15]}}, w_half};
            F3_W:    o_load_data = i_word;
            F3_BU:   o_load_data = {24'd0, w_byte};
            F3_HU:   o_load_data = {16'd0, w_half};
            default: o_load_data = '0;
        endcase
    end

    always_comb begin
        o_store_word = i_word;
        case (i_funct3)
            F3_B: o_store_word[{i_addr, 3'b000} +: 8] = i_wdata[7:0];
            F3_H: o_store_word[{i_addr[1], 4'b0000} +: 16] = i_wdata[15:0];
            F3_W: o_store_word = i_wdata;
            default: o_store_word = i_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Sequencer turning B/H/W load/store requests into word-wide memory accesses;
// sub-word stores are done as read-modify-write.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_fault,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [WORD_W-1:0] mem_in,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [WORD_W-1:0] mem_out
);

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [2:0]        r_funct3;
    logic              r_write;
    logic [WORD_W-1:0] r_wdata;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] r_rdata;
    logic              r_fault;

    logic [1:0]        w_sel_addr;
    logic [2:0]        w_sel_funct3;
    logic              w_sel_write;
    logic [WORD_W-1:0] w_sel_word;
    logic [WORD_W-1:0] w_load_data;
    logic [WORD_W-1:0] w_store_word;
    logic              w_fault;
    logic              w_idle;

    assign w_idle = (r_state == S_IDLE);

    // In IDLE the checker looks at the incoming request so a fault can be
    // decided at the accept edge; afterwards it works on the latched fields.
    always_comb begin
        w_sel_addr   = w_idle ? req_addr[1:0] : r_addr[1:0];
        w_sel_funct3 = w_idle ? req_funct3    : r_funct3;
        w_sel_write  = w_idle ? req_write     : r_write;
        w_sel_word   = (r_state == S_READ) ? mem_out : r_word;
    end

    lsu_align u_align (
        .i_addr       (w_sel_addr),
        .i_funct3     (w_sel_funct3),
        .i_write      (w_sel_write),
        .i_word       (w_sel_word),
        .i_wdata      (r_wdata),
        .o_load_data  (w_load_data),
        .o_store_word (w_store_word),
        .o_fault      (w_fault)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_addr   <= '0;
            r_funct3 <= '0;
            r_write  <= 1'b0;
            r_wdata  <= '0;
            r_word   <= '0;
            r_rdata  <= '0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_addr   <= req_addr;
                        r_funct3 <= req_funct3;
                        r_write  <= req_write;
                        r_wdata  <= req_wdata;
                        if (w_fault) begin
                            r_fault <= 1'b1;
                            r_rdata <= '0;
                            r_state <= S_RESP;
                        end else if (!req_write || req_funct3 != F3_W) begin
                            r_state <= S_READ;
                        end else begin
                            r_state <= S_WRITE;
                        end
                    end
                end
                S_READ: begin
                    r_word <= mem_out;
                    if (r_write) begin
                        r_state <= S_WRITE;
                    end else begin
                        r_rdata <= w_load_data;
                        r_fault <= 1'b0;
                        r_state <= S_RESP;
                    end
                end
                S_WRITE: begin
                    r_rdata <= '0;
                    r_fault <= 1'b0;
                    r_state <= S_RESP;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        req_ready       = w_idle;
        resp_valid      = (r_state == S_RESP);
        resp_rdata      = r_rdata;
        resp_fault      = r_fault;
        mem_access_addr = {2'b00, r_addr[ADDR_W-1:2]};
        mem_read_en     = (r_state == S_READ);
        mem_write_en    = (r_state == S_WRITE) & ~rst;
        mem_in          = (r_state == S_WRITE) ? w_store_word : '0;
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_fault;
    logic [31:0] mem_access_addr;
    logic [31:0] mem_in;
    logic        mem_write_en;
    logic        mem_read_en;
    logic [31:0] mem_out;

    logic [31:0] mem [0:63];
    logic        pre_we = 1'b0;
    logic [5:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    int n_checks = 0;
    int n_pass = 0;

    int          lat;
    logic        saw_rd, saw_wr, busy_ready;
    logic [31:0] en_addr;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32)) dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_write       (req_write),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_rdata      (resp_rdata),
        .resp_fault      (resp_fault),
        .mem_access_addr (mem_access_addr),
        .mem_in          (mem_in),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_out         (mem_out)
    );

    assign mem_out = mem[mem_access_addr[5:0]];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_addr] <= pre_data;
        else if (mem_write_en)
            mem[mem_access_addr[5:0]] <= mem_in;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic poke(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_we = 1'b1; pre_addr = a; pre_data = d;
        @(posedge clk);
        #1 pre_we = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] wd);
        int w;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = a; req_wdata = wd;
        w = 0;
        while (!req_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; saw_rd = 1'b0; saw_wr = 1'b0; busy_ready = 1'b0; en_addr = '0;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (mem_read_en) begin saw_rd = 1'b1; en_addr = mem_access_addr; end
            if (mem_write_en) begin saw_wr = 1'b1; en_addr = mem_access_addr; end
            if (resp_valid) begin
                lat = n;
                break;
            end
            if (req_ready) busy_ready = 1'b1;
        end
    endtask

    initial begin
        int seen;
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("rst_rdata", resp_rdata, 32'd0);
        check("rst_fault", {31'd0, resp_fault}, 32'd0);
        check("rst_rd_en", {31'd0, mem_read_en}, 32'd0);
        check("rst_wr_en", {31'd0, mem_write_en}, 32'd0);
        check("rst_addr", mem_access_addr, 32'd0);
        check("rst_mem_in", mem_in, 32'd0);
        check("rst_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;

        // Byte loads, signed and unsigned
        poke(6'd3, 32'h80FF_1234);
        do_req(1'b0, 3'b000, 32'h0F, '0);
        check("lb_lat", lat, 32'd2);
        check("lb_data", resp_rdata, 32'hFFFF_FF80);
        check("lb_fault", {31'd0, resp_fault}, 32'd0);
        check("lb_mem_addr", en_addr, 32'd3);
        check("lb_busy_ready", {31'd0, busy_ready}, 32'd0);
        do_req(1'b0, 3'b100, 32'h0F, '0);
        check("lbu_data", resp_rdata, 32'h0000_0080);

        // Sub-word stores (read-modify-write)
        poke(6'd3, 32'hAABB_CCDD);
        do_req(1'b1, 3'b000, 32'h0D, 32'h0000_0011);
        check("sb_lat", lat, 32'd3);
        check("sb_fault", {31'd0, resp_fault}, 32'd0);
        check("sb_rdata", resp_rdata, 32'd0);
        check("sb_mem", mem[3], 32'hAABB_11DD);
        do_req(1'b1, 3'b001, 32'h0E, 32'h0000_5566);
        check("sh_lat", lat, 32'd3);
        check("sh_mem", mem[3], 32'h5566_11DD);
        do_req(1'b0, 3'b001, 32'h0E, '0);
        check("lh_data", resp_rdata, 32'h0000_5566);
        poke(6'd4, 32'h8001_0000);
        do_req(1'b0, 3'b101, 32'h12, '0);
        check("lhu_data", resp_rdata, 32'h0000_8001);
        do_req(1'b0, 3'b001, 32'h12, '0);
        check("lh_neg_data", resp_rdata, 32'hFFFF_8001);
        do_req(1'b0, 3'b001, 32'h10, '0);
        check("lh_low_data", resp_rdata, 32'h0000_0000);

        // Faults: no memory activity, response one cycle after accept
        do_req(1'b0, 3'b010, 32'h06, '0);
        check("lw_mis_lat", lat, 32'd1);
        check("lw_mis_fault", {31'd0, resp_fault}, 32'd1);
        check("lw_mis_rdata", resp_rdata, 32'd0);
        check("lw_mis_en", {30'd0, saw_rd, saw_wr}, 32'd0);
        do_req(1'b0, 3'b011, 32'h08, '0);
        check("f3_011_fault", {31'd0, resp_fault}, 32'd1);
        check("f3_011_en", {30'd0, saw_rd, saw_wr}, 32'd0);
        do_req(1'b1, 3'b100, 32'h0C, 32'h0000_0077);
        check("sbu_fault", {31'd0, resp_fault}, 32'd1);
        check("sbu_lat", lat, 32'd1);
        check("sbu_en", {30'd0, saw_rd, saw_wr}, 32'd0);
        check("sbu_mem", mem[3], 32'h5566_11DD);
        do_req(1'b1, 3'b001, 32'h0D, 32'h0000_9999);
        check("sh_mis_fault", {31'd0, resp_fault}, 32'd1);

        // Word store then back-to-back load
        do_req(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF);
        check("sw_lat", lat, 32'd2);
        check("sw_rd_en", {31'd0, saw_rd}, 32'd0);
        check("sw_busy_ready", {31'd0, busy_ready}, 32'd0);
        do_req(1'b0, 3'b010, 32'h10, '0);
        check("lw_back_data", resp_rdata, 32'hDEAD_BEEF);
        check("lw_back_fault", {31'd0, resp_fault}, 32'd0);

        // Reset asserted during the WRITE cycle of an SB
        poke(6'd8, 32'h1234_5678);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h21; req_wdata = 32'h0000_00AB;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("abort_read_phase", {31'd0, mem_read_en}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1 check("abort_wr_gated", {31'd0, mem_write_en}, 32'd0);
        @(negedge clk);
        check("abort_mem", mem[8], 32'h1234_5678);
        check("abort_resp_valid", {31'd0, resp_valid}, 32'd0);
        check("abort_rdata", resp_rdata, 32'd0);
        check("abort_fault", {31'd0, resp_fault}, 32'd0);
        check("abort_addr", mem_access_addr, 32'd0);
        check("abort_mem_in", mem_in, 32'd0);
        check("abort_ready", {31'd0, req_ready}, 32'd1);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        check("abort_no_resp", seen, 32'd0);

        do_req(1'b0, 3'b000, 32'h20, '0);
        check("post_rst_lb", resp_rdata, 32'h0000_0078);
        check("post_rst_lat", lat, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
